scan_seq: RTL and testbench

Upstream select sequencer for the 3-to-8 line decoder. It steps a binary select code through the enabled output lines in ascending order. Each line is held for a programmable dwell time, in single-sweep or continuous mode. It drives the decoder's `in` input and qualifies it with `sel_valid`, so downstream logic can gate the decoder's one-hot output. Typical uses are display digit multiplexing and keypad row scanning.

---
 rtl/scan_pkg.sv | 13 +
 rtl/scan_next_idx.sv | 32 +++
 rtl/scan_seq.sv | 113 +++++++++++
 tb/tb_scan_seq.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/scan_pkg.sv
// Shared types and default sizing for the select-line scan sequencer.
package scan_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        DWELL = 1'b1
    } state_t;

    localparam int SEL_W_DEF   = 3;
    localparam int N_LINES_DEF = 8;
    localparam int DWELL_W_DEF = 8;

endpackage

// File: rtl/scan_next_idx.sv
// Combinational search over a line mask: the next enabled index above cur,
// whether one exists, and the lowest enabled index (the wrap target).
module scan_next_idx
    import scan_pkg::*;
#(
    parameter int SEL_W   = SEL_W_DEF,
    parameter int N_LINES = N_LINES_DEF
) (
    input  logic [N_LINES-1:0] mask,
    input  logic [SEL_W-1:0]   cur,
    output logic [SEL_W-1:0]   next_idx,
    output logic               has_next,
    output logic [SEL_W-1:0]   low_idx
);

    // Descending scan so the last hit is the smallest qualifying index.
    always_comb begin
        next_idx = '0;
        has_next = 1'b0;
        low_idx  = '0;
        for (int i = N_LINES - 1; i >= 0; i--) begin
            if (mask[i]) begin
                low_idx = SEL_W'(i);
                if (i > int'(cur)) begin
                    next_idx = SEL_W'(i);
                    has_next = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/scan_seq.sv
// Select sequencer for a 3-to-8 decoder: walks the enabled lines in ascending
// order, holding each for a programmable dwell, in single or continuous mode.
module scan_seq
    import scan_pkg::*;
#(
    parameter int SEL_W   = SEL_W_DEF,
    parameter int N_LINES = N_LINES_DEF,
    parameter int DWELL_W = DWELL_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               mode,
    input  logic [N_LINES-1:0] mask,
    input  logic [DWELL_W-1:0] dwell,
    output logic [SEL_W-1:0]   sel,
    output logic               sel_valid,
    output logic               busy,
    output logic               line_start,
    output logic               done
);

    state_t             state;
    logic [DWELL_W-1:0] cnt;
    logic [DWELL_W-1:0] reload_r;
    logic [N_LINES-1:0] mask_r;
    logic               mode_r;

    logic [N_LINES-1:0] search_mask;
    logic [SEL_W-1:0]   next_idx;
    logic [SEL_W-1:0]   low_idx;
    logic               has_next;
    logic [DWELL_W-1:0] dwell_m1;

    // In IDLE the search looks at the live mask to find the first line of a
    // new sweep; during a sweep it only ever sees the snapshot.
    assign search_mask = (state == IDLE) ? mask : mask_r;
    assign dwell_m1    = (dwell == '0) ? '0 : dwell - DWELL_W'(1);

    scan_next_idx #(
        .SEL_W  (SEL_W),
        .N_LINES(N_LINES)
    ) u_next (
        .mask    (search_mask),
        .cur     (sel),
        .next_idx(next_idx),
        .has_next(has_next),
        .low_idx (low_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            reload_r   <= '0;
            mask_r     <= '0;
            mode_r     <= 1'b0;
            sel        <= '0;
            sel_valid  <= 1'b0;
            busy       <= 1'b0;
            line_start <= 1'b0;
            done       <= 1'b0;
        end else begin
            line_start <= 1'b0;
            done       <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !stop) begin
                        if (mask != '0) begin
                            mask_r     <= mask;
                            mode_r     <= mode;
                            reload_r   <= dwell_m1;
                            cnt        <= dwell_m1;
                            sel        <= low_idx;
                            sel_valid  <= 1'b1;
                            busy       <= 1'b1;
                            line_start <= 1'b1;
                            state      <= DWELL;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                DWELL: begin
                    if (stop) begin
                        sel_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else if (cnt != '0) begin
                        cnt <= cnt - DWELL_W'(1);
                    end else if (has_next) begin
                        sel        <= next_idx;
                        line_start <= 1'b1;
                        cnt        <= reload_r;
                    end else if (mode_r) begin
                        sel        <= low_idx;
                        line_start <= 1'b1;
                        done       <= 1'b1;
                        cnt        <= reload_r;
                    end else begin
                        sel_valid <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_scan_seq.sv
// Bench for scan_seq: table of sweeps, hand-written corner sequences and
// randomized sweeps, all checked against a cycle-indexed sweep model.
module tb_scan_seq;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       stop;
    logic       mode;
    logic [7:0] mask;
    logic [7:0] dwell;
    logic [2:0] sel;
    logic       sel_valid;
    logic       busy;
    logic       line_start;
    logic       done;

    int n_vec = 0;
    int n_err = 0;

    scan_seq #(
        .SEL_W  (3),
        .N_LINES(8),
        .DWELL_W(8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .stop      (stop),
        .mode      (mode),
        .mask      (mask),
        .dwell     (dwell),
        .sel       (sel),
        .sel_valid (sel_valid),
        .busy      (busy),
        .line_start(line_start),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time expired, required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic chk_idle(input string tag, input logic exp_done);
        chk({tag, "_valid"}, 32'(sel_valid), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_ls"}, 32'(line_start), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'(exp_done));
    endtask

    // Single sweep: line p of the enabled list is shown for cycles
    // [p*deff, (p+1)*deff); done follows the last of them.
    task automatic run_single(input logic [7:0] m, input logic [7:0] d, input int exp_valid);
        int idx[$];
        int deff, k, total, vcount;
        for (int i = 0; i < 8; i++) if (m[i]) idx.push_back(i);
        k = idx.size();
        deff = (d == 0) ? 1 : int'(d);
        total = k * deff;
        vcount = 0;
        mask = m; dwell = d; mode = 1'b0; stop = 1'b0; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int c = 0; c < total; c++) begin
            @(negedge clk);
            chk("s_sel", 32'(sel), 32'(idx[c / deff]));
            chk("s_valid", 32'(sel_valid), 32'd1);
            chk("s_busy", 32'(busy), 32'd1);
            chk("s_ls", 32'(line_start), 32'((c % deff) == 0));
            chk("s_done", 32'(done), 32'd0);
            if (sel_valid) vcount++;
            // Inputs moved and a second start mid-sweep must all be ignored.
            if (total >= 3 && c == 0) begin
                mask = 8'($urandom); dwell = 8'($urandom); mode = 1'b1; start = 1'b1;
            end
            if (total >= 3 && c == 1) start = 1'b0;
        end
        @(negedge clk);
        chk_idle("s_end", 1'b1);
        chk("s_count", 32'(vcount), 32'(exp_valid));
    endtask

    // Continuous sweep stopped after nstop presented cycles.
    task automatic run_cont(input logic [7:0] m, input logic [7:0] d, input int nstop);
        int idx[$];
        int deff, k, p;
        logic ls;
        for (int i = 0; i < 8; i++) if (m[i]) idx.push_back(i);
        k = idx.size();
        deff = (d == 0) ? 1 : int'(d);
        mask = m; dwell = d; mode = 1'b1; stop = 1'b0; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int c = 0; c < nstop; c++) begin
            @(negedge clk);
            p = (c / deff) % k;
            ls = (c % deff) == 0;
            chk("c_sel", 32'(sel), 32'(idx[p]));
            chk("c_valid", 32'(sel_valid), 32'd1);
            chk("c_busy", 32'(busy), 32'd1);
            chk("c_ls", 32'(line_start), 32'(ls));
            chk("c_done", 32'(done), 32'(ls && p == 0 && c >= k * deff));
        end
        stop = 1'b1;
        @(posedge clk); #1 stop = 1'b0;
        @(negedge clk);
        chk_idle("c_stop", 1'b0);
    endtask

    task automatic run_empty();
        mask = 8'h00; dwell = 8'd2; mode = 1'($urandom_range(0, 1)); stop = 1'b0; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        chk_idle("e_pulse", 1'b1);
        @(negedge clk);
        chk_idle("e_after", 1'b0);
    endtask

    typedef struct {
        logic [7:0] mask;
        logic [7:0] dwell;
        logic       mode;
        int         nstop;
        int         exp_valid;
    } vec_t;

    vec_t tbl[8];

    initial begin
        logic [7:0] m, d;
        int deff, k;
        bit hit;

        tbl[0] = '{8'hFF, 8'd3,   1'b0, 0, 24};
        tbl[1] = '{8'hA4, 8'd0,   1'b1, 8, 0};
        tbl[2] = '{8'hA4, 8'd0,   1'b0, 0, 3};
        tbl[3] = '{8'h01, 8'd1,   1'b0, 0, 1};
        tbl[4] = '{8'h80, 8'd4,   1'b0, 0, 4};
        tbl[5] = '{8'h81, 8'd2,   1'b0, 0, 4};
        tbl[6] = '{8'hFF, 8'd0,   1'b0, 0, 8};
        tbl[7] = '{8'h18, 8'd2,   1'b1, 7, 0};

        rst_n = 1'b0; start = 1'b0; stop = 1'b0; mode = 1'b0; mask = '0; dwell = '0;
        #1;
        chk("rst_sel", 32'(sel), 32'd0);
        chk_idle("rst", 1'b0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        chk_idle("post_rst", 1'b0);

        // Table rows run back to back: each start lands in the previous done cycle.
        for (int i = 0; i < 8; i++) begin
            if (tbl[i].mode) run_cont(tbl[i].mask, tbl[i].dwell, tbl[i].nstop);
            else run_single(tbl[i].mask, tbl[i].dwell, tbl[i].exp_valid);
        end

        run_empty();

        // start and stop together in IDLE: nothing happens.
        mask = 8'hFF; dwell = 8'd1; mode = 1'b0; start = 1'b1; stop = 1'b1;
        @(posedge clk); #1 start = 1'b0; stop = 1'b0;
        @(negedge clk);
        chk_idle("ss_idle", 1'b0);
        @(negedge clk);
        chk_idle("ss_idle2", 1'b0);

        // Asynchronous reset in the middle of a sweep, while sel=5.
        mask = 8'hFF; dwell = 8'd3; mode = 1'b0; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        hit = 1'b0;
        for (int c = 0; c < 40 && !hit; c++) begin
            @(negedge clk);
            if (sel == 3'd5) hit = 1'b1;
        end
        chk("mid_reach5", 32'(hit), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_sel", 32'(sel), 32'd0);
        chk_idle("mid_rst", 1'b0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        chk_idle("mid_post", 1'b0);
        run_single(8'h24, 8'd2, 4);

        // Randomized sweeps.
        for (int r = 0; r < 20; r++) begin
            m = 8'($urandom);
            d = 8'($urandom_range(0, 4));
            deff = (d == 0) ? 1 : int'(d);
            k = $countones(m);
            if (m == 8'h00) run_empty();
            else if ($urandom_range(0, 1) == 1) run_cont(m, d, $urandom_range(1, 3 * k * deff));
            else run_single(m, d, k * deff);
        end

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
